// File: rtl/if_id_inst_queue.sv
// Circular instruction queue between fetch and the dual-slot ID decoders.
// Accepts up to two instructions per cycle and presents the two oldest, in program order.
module if_id_inst_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    input  logic [31:0]            in_inst0,
    input  logic [31:0]            in_inst1,
    input  logic [31:0]            in_pc0,
    input  logic [31:0]            in_pc1,
    output logic                   in_ready,
    output logic [1:0]             out_valid,
    output logic [31:0]            out_inst0,
    output logic [31:0]            out_inst1,
    output logic [31:0]            out_pc0,
    output logic [31:0]            out_pc1,
    input  logic [1:0]             out_accept,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic          push_fire;
    logic [CW-1:0] pushes;
    logic [CW-1:0] pops;
    logic [31:0]   wr0_inst;
    logic [31:0]   wr0_pc;

    // in_ready looks only at the registered count, so ID pops never reach it combinationally.
    always_comb begin
        in_ready     = (count <= CW'(DEPTH - 2));
        out_valid[0] = (count != '0);
        out_valid[1] = (count >= CW'(2));
        head_p1      = head + PW'(1);
        tail_p1      = tail + PW'(1);
        push_fire    = in_ready & ~flush & (|in_valid);
        pushes       = '0;
        if (push_fire) begin
            pushes = (in_valid == 2'b11) ? CW'(2) : CW'(1);
        end
        // Slot 1 may only retire alongside slot 0 to keep issue in order.
        pops = CW'(out_accept[0] & out_valid[0])
             + CW'(out_accept[1] & out_accept[0] & out_valid[1]);
        // A lone slot-1 fetch is compacted into the entry at tail.
        wr0_inst = in_valid[0] ? in_inst0 : in_inst1;
        wr0_pc   = in_valid[0] ? in_pc0   : in_pc1;
    end

    always_comb begin
        out_inst0 = '0;
        out_pc0   = '0;
        out_inst1 = '0;
        out_pc1   = '0;
        if (out_valid[0]) begin
            out_inst0 = inst_mem[head];
            out_pc0   = pc_mem[head];
        end
        if (out_valid[1]) begin
            out_inst1 = inst_mem[head_p1];
            out_pc1   = pc_mem[head_p1];
        end
    end

    // Storage is never reset; visibility is governed by count and output gating.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            inst_mem[tail] <= wr0_inst;
            pc_mem[tail]   <= wr0_pc;
            if (in_valid == 2'b11) begin
                inst_mem[tail_p1] <= in_inst1;
                pc_mem[tail_p1]   <= in_pc1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pops[PW-1:0];
            tail  <= tail + pushes[PW-1:0];
            count <= count + pushes - pops;
        end
    end
endmodule

// File: tb/tb_if_id_inst_queue.sv
// Bench for if_id_inst_queue: directed vector table plus a streaming wrap-around sequence
// checked against an expected-entry queue.
module tb_if_id_inst_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  in_valid, out_valid, out_accept;
    logic [31:0] in_inst0, in_inst1, in_pc0, in_pc1;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic        in_ready;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    if_id_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_accept(out_accept),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush;
        logic [1:0]  iv;
        logic [31:0] i0, p0, i1, p1;
        logic [1:0]  acc;
        logic [3:0]  e_cnt;
        logic [1:0]  e_val;
        logic        e_rdy;
        logic [31:0] e_i0, e_p0, e_i1, e_p1;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          k_next;

    function automatic logic [31:0] fi(int k);
        return 32'hA000_0000 + k;
    endfunction

    function automatic logic [31:0] fp(int k);
        return 32'h1C00_1000 + 4 * k;
    endfunction

    task automatic add(input logic r, input logic f, input logic [1:0] iv,
                       input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] acc,
                       input logic [3:0] ec, input logic [1:0] ev, input logic er,
                       input logic [31:0] ei0, input logic [31:0] ep0,
                       input logic [31:0] ei1, input logic [31:0] ep1);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv;
        v.i0 = i0; v.p0 = p0; v.i1 = i1; v.p1 = p1; v.acc = acc;
        v.e_cnt = ec; v.e_val = ev; v.e_rdy = er;
        v.e_i0 = ei0; v.e_p0 = ep0; v.e_i1 = ei1; v.e_p1 = ep1;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [3:0] ec, input logic [1:0] ev,
                                 input logic er, input logic [31:0] ei0, input logic [31:0] ep0,
                                 input logic [31:0] ei1, input logic [31:0] ep1);
        check("count", idx, 32'(count), 32'(ec));
        check("out_valid", idx, 32'(out_valid), 32'(ev));
        check("in_ready", idx, 32'(in_ready), 32'(er));
        check("out_inst0", idx, out_inst0, ei0);
        check("out_pc0", idx, out_pc0, ep0);
        check("out_inst1", idx, out_inst1, ei1);
        check("out_pc1", idx, out_pc1, ep1);
    endtask

    // One streaming cycle: model the pops/pushes on exp_q, drive the DUT, compare after the edge.
    task automatic stream_cycle(input int idx, input logic [1:0] iv, input logic [1:0] acc);
        int          npop;
        logic [63:0] e0, e1;
        @(negedge clk);
        rst = 0; flush = 0; in_valid = iv; out_accept = acc;
        in_inst0 = 32'hDEAD_0000; in_pc0 = 32'hDEAD_0004;
        in_inst1 = 32'hDEAD_0008; in_pc1 = 32'hDEAD_000C;
        npop = 0;
        if (acc[0] && exp_q.size() >= 1) npop++;
        if (acc[0] && acc[1] && exp_q.size() >= 2) npop++;
        if (DEPTH - exp_q.size() >= 2) begin
            if (iv[0]) begin
                in_inst0 = 32'h5000_0000 + k_next; in_pc0 = 32'h1C00_0000 + 4 * k_next;
                exp_q.push_back({in_inst0, in_pc0}); k_next++;
            end
            if (iv[1]) begin
                in_inst1 = 32'h5000_0000 + k_next; in_pc1 = 32'h1C00_0000 + 4 * k_next;
                exp_q.push_back({in_inst1, in_pc1}); k_next++;
            end
        end
        for (int n = 0; n < npop; n++) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        e0 = (exp_q.size() >= 1) ? exp_q[0] : 64'h0;
        e1 = (exp_q.size() >= 2) ? exp_q[1] : 64'h0;
        check_outputs(idx, 4'(exp_q.size()),
                      {exp_q.size() >= 2, exp_q.size() >= 1},
                      (DEPTH - exp_q.size()) >= 2,
                      e0[63:32], e0[31:0], e1[63:32], e1[31:0]);
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_accept = 0;
        in_inst0 = 0; in_inst1 = 0; in_pc0 = 0; in_pc1 = 0;

        // Reset, with a packet offered during reset that must be ignored.
        add(1,0,2'b00, 0,0,0,0, 2'b00, 0,2'b00,1, 0,0,0,0);
        add(1,0,2'b11, fi(90),fp(90),fi(91),fp(91), 2'b11, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b11, 32'h02800421,32'h1C000000,32'h02800842,32'h1C000004, 2'b00,
            2,2'b11,1, 32'h02800421,32'h1C000000,32'h02800842,32'h1C000004);
        // Fill to full; held pushes while not ready must not be written.
        add(1,0,2'b00, 0,0,0,0, 2'b00, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b11, fi(0),fp(0),fi(1),fp(1), 2'b00, 2,2'b11,1, fi(0),fp(0),fi(1),fp(1));
        add(0,0,2'b11, fi(2),fp(2),fi(3),fp(3), 2'b00, 4,2'b11,1, fi(0),fp(0),fi(1),fp(1));
        add(0,0,2'b11, fi(4),fp(4),fi(5),fp(5), 2'b00, 6,2'b11,1, fi(0),fp(0),fi(1),fp(1));
        add(0,0,2'b11, fi(6),fp(6),fi(7),fp(7), 2'b00, 8,2'b11,0, fi(0),fp(0),fi(1),fp(1));
        add(0,0,2'b11, fi(8),fp(8),fi(9),fp(9), 2'b01, 7,2'b11,0, fi(1),fp(1),fi(2),fp(2));
        add(0,0,2'b11, fi(8),fp(8),fi(9),fp(9), 2'b00, 7,2'b11,0, fi(1),fp(1),fi(2),fp(2));
        add(0,0,2'b00, 0,0,0,0, 2'b11, 5,2'b11,1, fi(3),fp(3),fi(4),fp(4));
        add(0,0,2'b00, 0,0,0,0, 2'b11, 3,2'b11,1, fi(5),fp(5),fi(6),fp(6));
        // In-order pop rule at count 3, then drain to empty.
        add(0,0,2'b00, 0,0,0,0, 2'b10, 3,2'b11,1, fi(5),fp(5),fi(6),fp(6));
        add(0,0,2'b00, 0,0,0,0, 2'b01, 2,2'b11,1, fi(6),fp(6),fi(7),fp(7));
        add(0,0,2'b00, 0,0,0,0, 2'b11, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b00, 0,0,0,0, 2'b11, 0,2'b00,1, 0,0,0,0);
        // Compacted single-slot pushes.
        add(0,0,2'b10, fi(99),fp(99),fi(20),fp(20), 2'b00, 1,2'b01,1, fi(20),fp(20),0,0);
        add(0,0,2'b01, fi(21),fp(21),fi(98),fp(98), 2'b00, 2,2'b11,1, fi(20),fp(20),fi(21),fp(21));
        add(0,0,2'b11, fi(22),fp(22),fi(23),fp(23), 2'b01, 3,2'b11,1, fi(21),fp(21),fi(22),fp(22));
        add(0,0,2'b11, fi(24),fp(24),fi(25),fp(25), 2'b00, 5,2'b11,1, fi(21),fp(21),fi(22),fp(22));
        // Flush at count 5 with concurrent push and pop; next push visible one cycle later.
        add(0,1,2'b11, fi(30),fp(30),fi(31),fp(31), 2'b11, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b11, fi(40),fp(40),fi(41),fp(41), 2'b00, 2,2'b11,1, fi(40),fp(40),fi(41),fp(41));
        add(0,0,2'b11, fi(42),fp(42),fi(43),fp(43), 2'b00, 4,2'b11,1, fi(40),fp(40),fi(41),fp(41));
        add(0,0,2'b11, fi(44),fp(44),fi(45),fp(45), 2'b00, 6,2'b11,1, fi(40),fp(40),fi(41),fp(41));
        // Reset mid-traffic, then reset together with flush.
        add(1,0,2'b11, fi(46),fp(46),fi(47),fp(47), 2'b11, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b00, 0,0,0,0, 2'b11, 0,2'b00,1, 0,0,0,0);
        add(1,1,2'b11, fi(48),fp(48),fi(49),fp(49), 2'b00, 0,2'b00,1, 0,0,0,0);
        add(0,0,2'b01, fi(50),fp(50),fi(97),fp(97), 2'b00, 1,2'b01,1, fi(50),fp(50),0,0);
        // Accept on both slots with only slot 0 valid pops exactly one.
        add(0,0,2'b00, 0,0,0,0, 2'b11, 0,2'b00,1, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
            in_inst0 = vecs[i].i0; in_pc0 = vecs[i].p0;
            in_inst1 = vecs[i].i1; in_pc1 = vecs[i].p1;
            out_accept = vecs[i].acc;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i].e_cnt, vecs[i].e_val, vecs[i].e_rdy,
                          vecs[i].e_i0, vecs[i].e_p0, vecs[i].e_i1, vecs[i].e_p1);
        end

        // Streaming across pointer wrap, including an odd head so slot 1 wraps to entry 0.
        @(negedge clk);
        rst = 1; in_valid = 0; out_accept = 0;
        @(posedge clk);
        exp_q.delete();
        k_next = 0;
        stream_cycle(100, 2'b01, 2'b00);
        stream_cycle(101, 2'b11, 2'b00);
        for (int c = 0; c < 10; c++) stream_cycle(102 + c, 2'b11, 2'b11);
        stream_cycle(112, 2'b10, 2'b01);
        for (int c = 0; c < 10; c++) stream_cycle(113 + c, 2'b11, 2'b11);
        stream_cycle(123, 2'b00, 2'b11);
        stream_cycle(124, 2'b00, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
